mips_trace_monitor: RTL and testbench
=====================================

Name: mips_trace_monitor

Overview:
Passive retirement-trace and performance-counter stage that sits directly downstream of the pipelined MIPS core.
- Consumes the core's per-cycle debug outputs: PC, instruction, write data, branch/zero, memwrite/regwrite, stall.
- Counts cycles, stalls, retired and taken-branch events.
- Buffers one trace record per retired cycle in a FIFO, drained by a valid/ready consumer (bench scoreboard or future debug port).
- Never back-pressures the core. Records that do not fit are dropped and counted.

Parameters:
DEPTH, 8, trace FIFO entries; power of two, >= 2
CNT_W, 16, width of every performance counter

Ports:
clock  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
clear  input  1  synchronous flush of FIFO, counters and overflow flag
PC  input  10  core PC debug output
Instruction_out  input  32  core instruction debug output
write_data_out  input  32  core register write-back data
Branch_out  input  1  branch control from core
Zero_out  input  1  ALU zero from core
MemWrite_out  input  1  memory write enable from core
RegWrite_out  input  1  register write enable from core
stall_out  input  1  core pipeline stall
trace_valid  output  1  FIFO head record is valid
trace_ready  input  1  consumer accepts head record
trace_pc  output  10  head record PC
trace_instr  output  32  head record instruction
trace_wdata  output  32  head record write data
trace_flags  output  3  head record flags: [2] taken, [1] memwr, [0] regwr
fifo_count  output  $clog2(DEPTH)+1  occupied entries
overflow  output  1  sticky: at least one record dropped
cnt_cycles  output  CNT_W  cycles since reset/clear
cnt_stalls  output  CNT_W  cycles with stall_out=1
cnt_retired  output  CNT_W  cycles with stall_out=0
cnt_taken  output  CNT_W  retired cycles with Branch_out & Zero_out
cnt_dropped  output  CNT_W  retire events lost because the FIFO was full

Behaviour:
- Reset (async, active-high): all outputs 0, FIFO empty, trace_valid=0, overflow=0.
- Retire event: rising edge with reset=0 and stall_out=0. Record = {PC, Instruction_out, write_data_out, {Branch_out&Zero_out, MemWrite_out, RegWrite_out}}, sampled on that edge.
- Latency: a record pushed on edge N is visible at the head (if FIFO was empty) immediately after edge N, so trace_valid=1 for cycle N+1.
- Pop: trace_valid & trace_ready at the rising edge. trace_* outputs are driven combinationally from the head entry. Head data is stable while trace_valid=1 and trace_ready=0.
- Push accepted when fifo_count<DEPTH, or when fifo_count==DEPTH and a pop occurs on the same edge. Full plus simultaneous push and pop: count unchanged, no drop.
- Empty: trace_ready ignored; a push still lands.
- Drop: a push is refused when full with no pop. Then cnt_dropped increments and overflow sets. Overflow stays set until reset or clear.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. fifo_count never exceeds DEPTH.
- Counters increment by 1 on their event each edge and saturate at 2^CNT_W-1; no wrap.
- cnt_cycles increments every edge with reset=0 and clear=0.
- clear=1: next edge empties FIFO, zeroes all counters, clears overflow. Events and pops in the same cycle are discarded; clear has priority.
- Reset asserted mid-operation discards FIFO contents immediately.
- Invariant: cnt_cycles == cnt_stalls + cnt_retired until saturation.

Optional Feature:
TRACE_FILTER_EN:
- Defined: a retire event pushes a record only if RegWrite_out | MemWrite_out | (Branch_out & Zero_out). Non-qualifying retires do not push and never count as drops. All counters are unchanged by the filter.
- Undefined: every retire event pushes a record.

Decomposition:
- Package mips_trace_pkg: trace_rec_t packed struct (pc 10, instr 32, wdata 32, flags 3); flag index constants FLG_REGWR=0, FLG_MEMWR=1, FLG_TAKEN=2.
- Sub-module mips_trace_fifo: parameterised by DEPTH and element type; provides push/pop/full/empty/count and synchronous flush.
- The top level holds the counters, event decode and the optional filter.

Test Plan:
- Reset, then 5 cycles stall_out=0, trace_ready=1, PC 0,4,8,12,16 -> 5 records popped in order with matching PC; cnt_retired=5, cnt_cycles=5, fifo_count ends 0.
- Alternate stall_out 1/0 for 10 cycles -> cnt_stalls=5, cnt_retired=5, exactly 5 records.
- trace_ready=0, 12 retires with DEPTH=8 -> fifo_count=8, cnt_dropped=4, overflow=1; then drain -> first 8 PCs in order.
- Full FIFO, push and pop on the same edge -> fifo_count stays 8, cnt_dropped unchanged, new PC lands at tail.
- Branch_out=1, Zero_out=1 on one retire -> record flags=3'b100, cnt_taken=1; Branch_out=1, Zero_out=0 -> flags[2]=0, cnt_taken unchanged.
- clear pulse with 3 queued records and a coincident retire -> next cycle fifo_count=0, all counters 0, overflow=0; with TRACE_FILTER_EN, a retire with RegWrite_out=0, MemWrite_out=0, not taken -> no record, cnt_retired increments.

Source files
------------

// File: rtl/mips_trace_pkg.sv
// Shared types for the MIPS retirement-trace monitor: trace record layout and flag bit indices.
package mips_trace_pkg;

    localparam int unsigned FLG_REGWR = 0;
    localparam int unsigned FLG_MEMWR = 1;
    localparam int unsigned FLG_TAKEN = 2;

    typedef struct packed {
        logic [9:0]  pc;
        logic [31:0] instr;
        logic [31:0] wdata;
        logic [2:0]  flags;
    } trace_rec_t;

endpackage

// File: rtl/mips_trace_fifo.sv
// Generic circular FIFO with synchronous flush; push is accepted when full only if a pop
// happens on the same edge.
module mips_trace_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter type         elem_t = logic [7:0]
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  elem_t                    din,
    output elem_t                    dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);

    elem_t           mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     cnt;
    logic            do_push;
    logic            do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (PW+1)'(DEPTH));
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & (~full | do_pop) & ~flush;
    assign dout    = mem[rd_ptr];
    assign count   = cnt;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mips_trace_monitor.sv
// Passive retirement trace buffer and saturating performance counters for the pipelined MIPS core.
// Optional macro TRACE_FILTER_EN: only push records that write a register, memory or take a branch.
module mips_trace_monitor
    import mips_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic [9:0]               PC,
    input  logic [31:0]              Instruction_out,
    input  logic [31:0]              write_data_out,
    input  logic                     Branch_out,
    input  logic                     Zero_out,
    input  logic                     MemWrite_out,
    input  logic                     RegWrite_out,
    input  logic                     stall_out,
    output logic                     trace_valid,
    input  logic                     trace_ready,
    output logic [9:0]               trace_pc,
    output logic [31:0]              trace_instr,
    output logic [31:0]              trace_wdata,
    output logic [2:0]               trace_flags,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic [CNT_W-1:0]         cnt_cycles,
    output logic [CNT_W-1:0]         cnt_stalls,
    output logic [CNT_W-1:0]         cnt_retired,
    output logic [CNT_W-1:0]         cnt_taken,
    output logic [CNT_W-1:0]         cnt_dropped
);

    logic       retire;
    logic       taken;
    logic       qualify;
    logic       push_req;
    logic       pop_req;
    logic       drop;
    logic       full;
    logic       empty;
    trace_rec_t rec_in;
    trace_rec_t head_raw;
    trace_rec_t head;

    assign retire = ~stall_out;
    assign taken  = Branch_out & Zero_out;

`ifdef TRACE_FILTER_EN
    assign qualify = RegWrite_out | MemWrite_out | taken;
`else
    assign qualify = 1'b1;
`endif

    always_comb begin
        rec_in                  = '0;
        rec_in.pc               = PC;
        rec_in.instr            = Instruction_out;
        rec_in.wdata            = write_data_out;
        rec_in.flags[FLG_TAKEN] = taken;
        rec_in.flags[FLG_MEMWR] = MemWrite_out;
        rec_in.flags[FLG_REGWR] = RegWrite_out;
    end

    assign push_req = retire & qualify & ~clear;
    assign pop_req  = trace_valid & trace_ready & ~clear;
    assign drop     = push_req & full & ~pop_req;

    mips_trace_fifo #(
        .DEPTH  (DEPTH),
        .elem_t (trace_rec_t)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (clear),
        .push  (push_req),
        .pop   (pop_req),
        .din   (rec_in),
        .dout  (head_raw),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    // Head fields read as zero when empty so outputs are clean out of reset.
    assign trace_valid = ~empty;
    assign head        = trace_valid ? head_raw : '0;
    assign trace_pc    = head.pc;
    assign trace_instr = head.instr;
    assign trace_wdata = head.wdata;
    assign trace_flags = head.flags;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_cycles  <= '0;
            cnt_stalls  <= '0;
            cnt_retired <= '0;
            cnt_taken   <= '0;
            cnt_dropped <= '0;
            overflow    <= 1'b0;
        end else if (clear) begin
            cnt_cycles  <= '0;
            cnt_stalls  <= '0;
            cnt_retired <= '0;
            cnt_taken   <= '0;
            cnt_dropped <= '0;
            overflow    <= 1'b0;
        end else begin
            cnt_cycles  <= sat_inc(cnt_cycles, 1'b1);
            cnt_stalls  <= sat_inc(cnt_stalls, stall_out);
            cnt_retired <= sat_inc(cnt_retired, retire);
            cnt_taken   <= sat_inc(cnt_taken, retire & taken);
            cnt_dropped <= sat_inc(cnt_dropped, drop);
            overflow    <= overflow | drop;
        end
    end

endmodule

// File: tb/tb_mips_trace_monitor.sv
// Self-checking bench for mips_trace_monitor: directed scenarios plus randomized traffic against a
// queue-based reference model.
module tb_mips_trace_monitor;

    localparam int DEPTH = 8;
    localparam int CNT_W = 16;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int MAXC  = (1 << CNT_W) - 1;
`ifdef TRACE_FILTER_EN
    localparam int FILT = 1;
`else
    localparam int FILT = 0;
`endif

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              clear = 1'b0;
    logic [9:0]        PC = '0;
    logic [31:0]       Instruction_out = '0;
    logic [31:0]       write_data_out = '0;
    logic              Branch_out = 1'b0;
    logic              Zero_out = 1'b0;
    logic              MemWrite_out = 1'b0;
    logic              RegWrite_out = 1'b1;
    logic              stall_out = 1'b1;
    logic              trace_ready = 1'b0;
    logic              trace_valid;
    logic [9:0]        trace_pc;
    logic [31:0]       trace_instr;
    logic [31:0]       trace_wdata;
    logic [2:0]        trace_flags;
    logic [CW-1:0]     fifo_count;
    logic              overflow;
    logic [CNT_W-1:0]  cnt_cycles;
    logic [CNT_W-1:0]  cnt_stalls;
    logic [CNT_W-1:0]  cnt_retired;
    logic [CNT_W-1:0]  cnt_taken;
    logic [CNT_W-1:0]  cnt_dropped;

    always #5 clock = ~clock;

    mips_trace_monitor #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock           (clock),
        .reset           (reset),
        .clear           (clear),
        .PC              (PC),
        .Instruction_out (Instruction_out),
        .write_data_out  (write_data_out),
        .Branch_out      (Branch_out),
        .Zero_out        (Zero_out),
        .MemWrite_out    (MemWrite_out),
        .RegWrite_out    (RegWrite_out),
        .stall_out       (stall_out),
        .trace_valid     (trace_valid),
        .trace_ready     (trace_ready),
        .trace_pc        (trace_pc),
        .trace_instr     (trace_instr),
        .trace_wdata     (trace_wdata),
        .trace_flags     (trace_flags),
        .fifo_count      (fifo_count),
        .overflow        (overflow),
        .cnt_cycles      (cnt_cycles),
        .cnt_stalls      (cnt_stalls),
        .cnt_retired     (cnt_retired),
        .cnt_taken       (cnt_taken),
        .cnt_dropped     (cnt_dropped)
    );

    typedef struct packed {
        logic [9:0]  pc;
        logic [31:0] instr;
        logic [31:0] wdata;
        logic [2:0]  flags;
    } mrec_t;

    int          errors = 0;
    int          checks = 0;
    mrec_t       mq[$];
    logic [9:0]  popped[$];
    int          m_cycles, m_stalls, m_retired, m_taken, m_dropped;
    bit          m_ovf;

    function automatic int sat(input int v);
        return (v >= MAXC) ? MAXC : v + 1;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_cycles = 0; m_stalls = 0; m_retired = 0; m_taken = 0; m_dropped = 0;
        m_ovf = 0;
    endtask

    // Advance one clock: update the model from the current inputs, then settle to the negedge.
    task automatic cycle();
        bit    pop;
        bit    qual;
        mrec_t r;
        if (trace_valid && trace_ready && !clear) popped.push_back(trace_pc);
        if (clear) begin
            model_reset();
        end else begin
            m_cycles = sat(m_cycles);
            pop = (mq.size() > 0) && trace_ready;
            if (pop) void'(mq.pop_front());
            if (stall_out) begin
                m_stalls = sat(m_stalls);
            end else begin
                m_retired = sat(m_retired);
                if (Branch_out && Zero_out) m_taken = sat(m_taken);
                qual = (FILT == 0) || RegWrite_out || MemWrite_out || (Branch_out && Zero_out);
                if (qual) begin
                    r.pc = PC; r.instr = Instruction_out; r.wdata = write_data_out;
                    r.flags = {Branch_out & Zero_out, MemWrite_out, RegWrite_out};
                    if (mq.size() < DEPTH) mq.push_back(r);
                    else begin
                        m_dropped = sat(m_dropped);
                        m_ovf = 1;
                    end
                end
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1; clear = 1'b0; stall_out = 1'b1; trace_ready = 1'b0;
        Branch_out = 1'b0; Zero_out = 1'b0; MemWrite_out = 1'b0; RegWrite_out = 1'b1;
        model_reset();
        popped.delete();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall_out = 1'b0; trace_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        checks++; if (fifo_count !== '0) begin errors++;
            $display("FAIL reset_count got=%0d want=0", fifo_count); end
        checks++; if (cnt_cycles !== '0 || cnt_retired !== '0) begin errors++;
            $display("FAIL reset_counters cycles=%0d retired=%0d want=0", cnt_cycles, cnt_retired); end
        do_reset();
        checks++; if (trace_valid !== 1'b0 || overflow !== 1'b0 || trace_pc !== '0) begin errors++;
            $display("FAIL reset_outputs valid=%b ovf=%b pc=%0d want 0", trace_valid, overflow, trace_pc); end
    endtask

    task automatic test_sequential_pc();
        do_reset();
        trace_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            stall_out = 1'b0; PC = 10'(i * 4);
            Instruction_out = $urandom; write_data_out = $urandom;
            cycle();
            checks++; if (trace_valid !== 1'b1 || trace_pc !== 10'(i * 4)) begin errors++;
                $display("FAIL seq_head[%0d] valid=%b pc=%0d want valid=1 pc=%0d",
                         i, trace_valid, trace_pc, i * 4); end
        end
        checks++; if (cnt_retired !== 16'd5 || cnt_cycles !== 16'd5) begin errors++;
            $display("FAIL seq_counters retired=%0d cycles=%0d want 5/5", cnt_retired, cnt_cycles); end
        stall_out = 1'b1;
        cycle();
        checks++; if (fifo_count !== '0 || popped.size() != 5) begin errors++;
            $display("FAIL seq_drain count=%0d popped=%0d want 0/5", fifo_count, popped.size()); end
        for (int i = 0; i < popped.size() && i < 5; i++) begin
            checks++; if (popped[i] !== 10'(i * 4)) begin errors++;
                $display("FAIL seq_order[%0d] got=%0d want=%0d", i, popped[i], i * 4); end
        end
    endtask

    task automatic test_alt_stall();
        do_reset();
        trace_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            stall_out = (i % 2 == 0); PC = 10'(i);
            cycle();
        end
        checks++; if (cnt_stalls !== 16'd5 || cnt_retired !== 16'd5) begin errors++;
            $display("FAIL alt_counters stalls=%0d retired=%0d want 5/5", cnt_stalls, cnt_retired); end
        stall_out = 1'b1;
        cycle();
        checks++; if (popped.size() != 5) begin errors++;
            $display("FAIL alt_records got=%0d want=5", popped.size()); end
    endtask

    task automatic test_overflow();
        logic [9:0] want;
        do_reset();
        trace_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            stall_out = 1'b0; PC = 10'(i * 4);
            cycle();
        end
        checks++; if (fifo_count !== CW'(8) || cnt_dropped !== 16'd4 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_fill count=%0d dropped=%0d ovf=%b want 8/4/1",
                     fifo_count, cnt_dropped, overflow); end
        // Full with simultaneous push and pop: no drop, count unchanged.
        trace_ready = 1'b1; stall_out = 1'b0; PC = 10'd200;
        cycle();
        checks++; if (fifo_count !== CW'(8) || cnt_dropped !== 16'd4) begin errors++;
            $display("FAIL full_pushpop count=%0d dropped=%0d want 8/4", fifo_count, cnt_dropped); end
        stall_out = 1'b1;
        for (int i = 0; i < 8; i++) cycle();
        checks++; if (popped.size() != 9 || fifo_count !== '0 || overflow !== 1'b1) begin errors++;
            $display("FAIL ovf_drain popped=%0d count=%0d ovf=%b want 9/0/1",
                     popped.size(), fifo_count, overflow); end
        for (int i = 0; i < popped.size() && i < 9; i++) begin
            want = (i == 8) ? 10'd200 : 10'(i * 4);
            checks++; if (popped[i] !== want) begin errors++;
                $display("FAIL ovf_order[%0d] got=%0d want=%0d", i, popped[i], want); end
        end
    endtask

    task automatic test_taken();
        do_reset();
        trace_ready = 1'b0; stall_out = 1'b0;
        Branch_out = 1'b1; Zero_out = 1'b1; RegWrite_out = 1'b0; MemWrite_out = 1'b0;
        cycle();
        Zero_out = 1'b0; RegWrite_out = 1'b1;
        cycle();
        stall_out = 1'b1;
        checks++; if (trace_flags !== 3'b100 || cnt_taken !== 16'd1) begin errors++;
            $display("FAIL taken_flags flags=%b taken=%0d want 100/1", trace_flags, cnt_taken); end
        trace_ready = 1'b1;
        cycle();
        checks++; if (trace_flags !== 3'b001 || cnt_taken !== 16'd1) begin errors++;
            $display("FAIL nottaken_flags flags=%b taken=%0d want 001/1", trace_flags, cnt_taken); end
        Branch_out = 1'b0;
    endtask

    task automatic test_clear();
        do_reset();
        trace_ready = 1'b0; stall_out = 1'b0;
        for (int i = 0; i < 9; i++) begin PC = 10'(i); cycle(); end
        trace_ready = 1'b1; stall_out = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        checks++; if (fifo_count !== CW'(3) || overflow !== 1'b1) begin errors++;
            $display("FAIL clear_setup count=%0d ovf=%b want 3/1", fifo_count, overflow); end
        clear = 1'b1; stall_out = 1'b0; trace_ready = 1'b1;
        cycle();
        clear = 1'b0; stall_out = 1'b1; trace_ready = 1'b0;
        checks++; if (fifo_count !== '0 || trace_valid !== 1'b0 || overflow !== 1'b0) begin errors++;
            $display("FAIL clear_fifo count=%0d valid=%b ovf=%b want 0", fifo_count, trace_valid,
                     overflow); end
        checks++; if ((cnt_cycles | cnt_stalls | cnt_retired | cnt_taken | cnt_dropped) !== '0) begin
            errors++;
            $display("FAIL clear_counters cyc=%0d st=%0d ret=%0d tk=%0d dr=%0d want 0",
                     cnt_cycles, cnt_stalls, cnt_retired, cnt_taken, cnt_dropped); end
        cycle();
        checks++; if (cnt_cycles !== 16'd1 || cnt_stalls !== 16'd1) begin errors++;
            $display("FAIL post_clear cyc=%0d st=%0d want 1/1", cnt_cycles, cnt_stalls); end
    endtask

    task automatic test_filter();
        do_reset();
        trace_ready = 1'b0; stall_out = 1'b0;
        RegWrite_out = 1'b0; MemWrite_out = 1'b0; Branch_out = 1'b0; Zero_out = 1'b1;
        cycle();
        stall_out = 1'b1; RegWrite_out = 1'b1;
        checks++; if (cnt_retired !== 16'd1 || fifo_count !== CW'(1 - FILT)) begin errors++;
            $display("FAIL filter count=%0d retired=%0d want %0d/1", fifo_count, cnt_retired, 1 - FILT);
        end
        checks++; if (cnt_dropped !== '0) begin errors++;
            $display("FAIL filter_drop got=%0d want=0", cnt_dropped); end
    endtask

    task automatic test_async_reset();
        do_reset();
        trace_ready = 1'b0; stall_out = 1'b0;
        for (int i = 0; i < 3; i++) begin PC = 10'(i); cycle(); end
        reset = 1'b1;
        #1;
        checks++; if (fifo_count !== '0 || trace_valid !== 1'b0 || cnt_retired !== '0) begin errors++;
            $display("FAIL async_reset count=%0d valid=%b retired=%0d want 0", fifo_count,
                     trace_valid, cnt_retired); end
        model_reset();
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            stall_out       = ($urandom_range(0, 3) == 0);
            trace_ready     = ($urandom_range(0, 2) == 0);
            clear           = ($urandom_range(0, 59) == 0);
            PC              = 10'($urandom);
            Instruction_out = $urandom;
            write_data_out  = $urandom;
            Branch_out      = 1'($urandom);
            Zero_out        = 1'($urandom);
            MemWrite_out    = ($urandom_range(0, 3) == 0);
            RegWrite_out    = ($urandom_range(0, 1) == 0);
            cycle();
            checks++; if (fifo_count !== CW'(mq.size()) || trace_valid !== (mq.size() > 0)) begin
                errors++;
                $display("FAIL rnd_count[%0d] count=%0d valid=%b want %0d", n, fifo_count,
                         trace_valid, mq.size()); end
            if (mq.size() > 0) begin
                checks++;
                if ({trace_pc, trace_instr, trace_wdata, trace_flags} !== mq[0]) begin errors++;
                    $display("FAIL rnd_head[%0d] got=%h want=%h", n,
                             {trace_pc, trace_instr, trace_wdata, trace_flags}, mq[0]); end
            end
            checks++;
            if (cnt_cycles !== CNT_W'(m_cycles) || cnt_stalls !== CNT_W'(m_stalls) ||
                cnt_retired !== CNT_W'(m_retired) || cnt_taken !== CNT_W'(m_taken) ||
                cnt_dropped !== CNT_W'(m_dropped) || overflow !== m_ovf) begin errors++;
                $display("FAIL rnd_counters[%0d] got=%0d/%0d/%0d/%0d/%0d/%b want=%0d/%0d/%0d/%0d/%0d/%b",
                         n, cnt_cycles, cnt_stalls, cnt_retired, cnt_taken, cnt_dropped, overflow,
                         m_cycles, m_stalls, m_retired, m_taken, m_dropped, m_ovf); end
            checks++; if (cnt_cycles !== cnt_stalls + cnt_retired) begin errors++;
                $display("FAIL rnd_invariant[%0d] cycles=%0d stalls+retired=%0d", n, cnt_cycles,
                         cnt_stalls + cnt_retired); end
        end
        clear = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential_pc();
        test_alt_stall();
        test_overflow();
        test_taken();
        test_clear();
        test_filter();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
